// File: rtl/drive_mode_ctrl.sv
// Driving-mode controller for the simulated car: power-on hold detection, five-state
// driving FSM, latched travel direction, idle auto power-off and a saturating odometer.
//
// state        | meaning
// -------------+------------------------------------------------------------
// ST_OFF       | powered down; waits for a fresh, held press of the power button
// ST_ON        | powered, idle; times out back to ST_OFF unless manual mode chosen
// ST_NOT_START | manual mode selected, engine not started
// ST_START     | engine started, car stationary
// ST_MOVING    | car moving in the latched direction
module drive_mode_ctrl #(
   parameter int POWER_HOLD_CYCLES = 100000000,
   parameter int IDLE_CYCLES       = 1000000000,
   parameter int MILE_TICK_CYCLES  = 100000000,
   parameter int MILE_W            = 16
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              power_on_signal,
   input  logic              power_off_signal,
   input  logic              manual_driving_signal,
   input  logic              throttle_signal,
   input  logic              clutch_signal,
   input  logic              brake_signal,
   input  logic              reverse_signal,
   input  logic              turn_left_signal,
   input  logic              turn_right_signal,
   input  logic              mileage_clr,
   output logic [3:0]        state_code,
   output logic [3:0]        cmd,
   output logic [MILE_W-1:0] mileage,
   output logic              idle_off_pulse
);

   localparam int HOLD_W = (POWER_HOLD_CYCLES > 1) ? $clog2(POWER_HOLD_CYCLES) : 1;
   localparam int IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam int TICK_W = (MILE_TICK_CYCLES > 1) ? $clog2(MILE_TICK_CYCLES) : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POWER_HOLD_CYCLES - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MILE_TICK_CYCLES - 1);
   localparam logic [MILE_W-1:0] MILE_MAX  = '1;
   localparam logic              IDLE_EN   = (IDLE_CYCLES != 0);

   typedef enum logic [3:0] {
      ST_OFF       = 4'd0,
      ST_ON        = 4'd1,
      ST_NOT_START = 4'd2,
      ST_START     = 4'd3,
      ST_MOVING    = 4'd4
   } state_t;

   state_t              state_q, state_d;
   logic                arm_q, arm_d;
   logic                dir_q, dir_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [MILE_W-1:0]   mile_q, mile_d;
   logic [3:0]          cmd_q, cmd_d;
   logic [1:0]          turn;
   logic                idle_fire;

   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_OFF;
         arm_q   <= 1'b0;
         dir_q   <= 1'b0;
         hold_q  <= '0;
         idle_q  <= '0;
         tick_q  <= '0;
         mile_q  <= '0;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         arm_q   <= arm_d;
         dir_q   <= dir_d;
         hold_q  <= hold_d;
         idle_q  <= idle_d;
         tick_q  <= tick_d;
         mile_q  <= mile_d;
         cmd_q   <= cmd_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      arm_d     = arm_q;
      hold_d    = hold_q;
      idle_d    = '0;
      dir_d     = dir_q;
      idle_fire = 1'b0;
      case (state_q)
         ST_OFF: begin
            // arm only after a release so a press still held from before cannot re-power
            if (!power_on_signal) begin
               arm_d  = 1'b1;
               hold_d = '0;
            end else if (arm_q) begin
               if (hold_q == HOLD_LAST) begin
                  state_d = ST_ON;
                  hold_d  = '0;
                  arm_d   = 1'b0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end
         ST_ON: begin
            if (manual_driving_signal) begin
               state_d = ST_NOT_START;
            end else if (IDLE_EN && idle_q == IDLE_LAST) begin
               state_d   = ST_OFF;
               idle_fire = 1'b1;
            end else if (IDLE_EN) begin
               idle_d = idle_q + 1'b1;
            end
         end
         ST_NOT_START: begin
            if (throttle_signal && clutch_signal && !brake_signal) state_d = ST_START;
            else if (throttle_signal && !clutch_signal)            state_d = ST_OFF;
         end
         ST_START: begin
            if (brake_signal) begin
               state_d = ST_NOT_START;
            end else if (throttle_signal && !clutch_signal) begin
               state_d = ST_MOVING;
               dir_d   = reverse_signal;
            end
         end
         ST_MOVING: begin
            if (!clutch_signal && (reverse_signal != dir_q)) state_d = ST_OFF;
            else if (brake_signal)                           state_d = ST_NOT_START;
            else if (clutch_signal || !throttle_signal)      state_d = ST_START;
         end
         default: state_d = ST_OFF;
      endcase
      if (power_off_signal && state_q != ST_OFF) begin
         state_d   = ST_OFF;
         idle_fire = 1'b0;
      end
   end

   always_comb begin
      turn  = {turn_right_signal, turn_left_signal} &
              {2{~(turn_right_signal & turn_left_signal)}};
      cmd_d = '0;
      if (state_q == ST_START)       cmd_d = {turn, 2'b00};
      else if (state_q == ST_MOVING) cmd_d = {turn, dir_q, ~dir_q};
   end

   always_comb begin
      tick_d = tick_q;
      mile_d = mile_q;
      if (mileage_clr) begin
         tick_d = '0;
         mile_d = '0;
      end else if (state_q == ST_MOVING) begin
         if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (mile_q != MILE_MAX) mile_d = mile_q + 1'b1;
         end else begin
            tick_d = tick_q + 1'b1;
         end
      end
   end

   assign state_code     = state_q;
   assign cmd            = cmd_q;
   assign mileage        = mile_q;
   assign idle_off_pulse = idle_fire;

endmodule

// File: tb/tb_drive_mode_ctrl.sv
// Directed bench for drive_mode_ctrl with a cycle-level reference model checked every
// negative edge, plus hand-computed literal checkpoints along the scenario.
module tb_drive_mode_ctrl;

   localparam int HOLD = 4;
   localparam int IDLE = 8;
   localparam int TICK = 5;
   localparam int MW   = 3;
   localparam int MMAX = 7;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic pon = 0, poff = 0, man = 0, thr = 0, clu = 0, brk = 0, rev = 0, tl = 0, tr = 0, mclr = 0;
   logic [3:0]    state_code, cmd;
   logic [MW-1:0] mileage;
   logic          idle_off_pulse;

   int total = 0;
   int bad = 0;

   int m_state, m_hold, m_on, m_tick, m_mile, m_cmd;
   bit m_arm, m_dir;

   drive_mode_ctrl #(
      .POWER_HOLD_CYCLES(HOLD),
      .IDLE_CYCLES(IDLE),
      .MILE_TICK_CYCLES(TICK),
      .MILE_W(MW)
   ) dut (
      .sys_clk(clk),
      .rst(rst_n),
      .power_on_signal(pon),
      .power_off_signal(poff),
      .manual_driving_signal(man),
      .throttle_signal(thr),
      .clutch_signal(clu),
      .brake_signal(brk),
      .reverse_signal(rev),
      .turn_left_signal(tl),
      .turn_right_signal(tr),
      .mileage_clr(mclr),
      .state_code(state_code),
      .cmd(cmd),
      .mileage(mileage),
      .idle_off_pulse(idle_off_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic m_reset();
      m_state = 0; m_hold = 0; m_on = 0; m_tick = 0; m_mile = 0; m_cmd = 0;
      m_arm = 0; m_dir = 0;
   endtask

   task automatic m_step();
      int ns;
      int nc;
      ns = m_state;
      nc = 0;
      if (m_state == 3 || m_state == 4) begin
         if (tl && !tr) nc = 4;
         else if (tr && !tl) nc = 8;
         if (m_state == 4) nc = nc + (m_dir ? 2 : 1);
      end
      if (mclr) begin
         m_tick = 0;
         m_mile = 0;
      end else if (m_state == 4) begin
         m_tick++;
         if (m_tick == TICK) begin
            m_tick = 0;
            if (m_mile < MMAX) m_mile++;
         end
      end
      case (m_state)
         0: if (!pon) begin
               m_arm = 1; m_hold = 0;
            end else if (m_arm) begin
               m_hold++;
               if (m_hold == HOLD) begin ns = 1; m_hold = 0; m_arm = 0; end
            end
         1: if (man) ns = 2;
            else if (m_on == IDLE - 1) ns = 0;
            else m_on++;
         2: if (thr && clu && !brk) ns = 3;
            else if (thr && !clu) ns = 0;
         3: if (brk) ns = 2;
            else if (thr && !clu) begin ns = 4; m_dir = rev; end
         4: if (!clu && (rev != m_dir)) ns = 0;
            else if (brk) ns = 2;
            else if (clu || !thr) ns = 3;
         default: ns = 0;
      endcase
      if (m_state != 0 && poff) ns = 0;
      if (ns == 1 && m_state != 1) m_on = 0;
      m_state = ns;
      m_cmd = nc;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) m_reset();
         else m_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("state", state_code, m_state);
         chk("cmd", cmd, m_cmd);
         chk("mileage", mileage, m_mile);
         chk("pulse", idle_off_pulse,
             (m_state == 1 && !poff && !man && m_on == IDLE - 1) ? 1 : 0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic power_to_ns();
      pon = 0; step(1);
      pon = 1; step(4);
      pon = 0; man = 1; step(1);
      man = 0;
   endtask

   initial begin
      #1 rst_n = 0;
      #10 rst_n = 1;
      step(1);
      chk("reset_state", state_code, 0);
      chk("reset_cmd", cmd, 0);
      chk("reset_mileage", mileage, 0);
      chk("reset_pulse", idle_off_pulse, 0);

      // power-on hold
      pon = 1; step(3);
      pon = 0; step(1);
      chk("short_hold", state_code, 0);
      pon = 1; step(3);
      chk("hold3", state_code, 0);
      step(1);
      chk("hold4", state_code, 1);
      poff = 1; step(1);
      chk("forced_off", state_code, 0);
      poff = 0; step(6);
      chk("no_rearm", state_code, 0);
      pon = 0; step(1);
      pon = 1; step(4);
      chk("repower", state_code, 1);

      // idle timeout
      pon = 0;
      chk("pulse_early", idle_off_pulse, 0);
      step(7);
      chk("idle_pulse", idle_off_pulse, 1);
      chk("idle_pulse_state", state_code, 1);
      step(1);
      chk("idle_off", state_code, 0);
      chk("pulse_gone", idle_off_pulse, 0);

      // manual wins over timeout
      pon = 0; step(1);
      pon = 1; step(4);
      chk("repower2", state_code, 1);
      pon = 0; step(7);
      man = 1; #1;
      chk("manual_no_pulse", idle_off_pulse, 0);
      step(1);
      chk("manual_ns", state_code, 2);
      man = 0;

      // forward launch and turns
      thr = 1; clu = 1; step(1);
      chk("to_starting", state_code, 3);
      clu = 0; step(1);
      chk("to_moving", state_code, 4);
      chk("cmd_latency", cmd, 0);
      step(1);
      chk("cmd_fwd", cmd, 4'b0001);
      tl = 1; step(1);
      chk("cmd_fwd_left", cmd, 4'b0101);
      tr = 1; step(1);
      chk("cmd_both_turn", cmd, 4'b0001);
      tl = 0; tr = 0;

      // gear change without clutch stalls
      rev = 1; step(1);
      chk("gear_stall", state_code, 0);
      rev = 0; thr = 0; step(1);
      chk("cmd_after_stall", cmd, 0);

      // reverse launch, clutch-covered gear change, brake, not_starting stall
      power_to_ns();
      thr = 1; clu = 1; step(1);
      rev = 1; clu = 0; step(1);
      chk("rev_moving", state_code, 4);
      step(1);
      chk("cmd_rev", cmd, 4'b0010);
      clu = 1; rev = 0; step(1);
      chk("clutch_no_stall", state_code, 3);
      brk = 1; step(1);
      chk("brake_ns", state_code, 2);
      brk = 0; clu = 0; step(1);
      chk("ns_stall", state_code, 0);
      thr = 0;

      // mileage
      power_to_ns();
      thr = 1; clu = 1; step(1);
      mclr = 1; clu = 0; rev = 0; step(1);
      mclr = 0;
      chk("mile_clr_start", mileage, 0);
      chk("mile_moving", state_code, 4);
      step(12);
      chk("mile_12", mileage, 2);
      clu = 1; step(1);
      step(2);
      chk("mile_starting", state_code, 3);
      clu = 0; step(1);
      step(1);
      chk("mile_held", mileage, 2);
      step(1);
      chk("mile_3", mileage, 3);
      step(20);
      chk("mile_7", mileage, 7);
      step(5);
      chk("mile_sat", mileage, 7);
      mclr = 1; step(1);
      chk("mile_clr", mileage, 0);
      mclr = 0; step(7);
      chk("mile_1", mileage, 1);
      poff = 1; step(1);
      chk("mile_off_state", state_code, 0);
      poff = 0; step(3);
      chk("mile_retained", mileage, 1);

      // asynchronous reset while moving
      thr = 0;
      power_to_ns();
      thr = 1; clu = 1; step(1);
      clu = 0; step(1);
      step(6);
      chk("pre_reset_mileage", mileage, 2);
      chk("pre_reset_cmd", cmd, 4'b0001);
      #1 rst_n = 0;
      #1;
      chk("async_state", state_code, 0);
      chk("async_cmd", cmd, 0);
      chk("async_mileage", mileage, 0);
      step(2);
      rst_n = 1;
      thr = 0;
      step(2);
      chk("post_reset", state_code, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
